// File: rtl/uart_tx_sequencer_pkg.sv
// Shared types and default widths for the UART transmit sequencer and its board-level wrapper.
// No logic here; the state encoding is visible so a waveform viewer shows names, not numbers.
package uart_tx_sequencer_pkg;

  localparam int DBITS_DEF      = 8;
  localparam int FIFO_EXP_DEF   = 2;
  localparam int GAP_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    GAP
  } tx_seq_state_t;

endpackage

// File: rtl/uart_tx_sequencer_if.sv
// Control, transmitter-handshake and status signals of the sequencer, bundled as one port.
// The slave side is the sequencer itself; the master side is the switches/buttons/transmitter.
interface uart_tx_sequencer_if
  import uart_tx_sequencer_pkg::*;
#(
  parameter int DBITS    = DBITS_DEF,
  parameter int FIFO_EXP = FIFO_EXP_DEF
);

  logic                load;
  logic [DBITS-1:0]    load_data;
  logic                send_one;
  logic                send_all;
  logic                tx_done;
  logic                tx_start;
  logic [DBITS-1:0]    tx_data;
  logic [DBITS-1:0]    oldest;
  logic [FIFO_EXP:0]   count;
  logic                full;
  logic                empty;
  logic                busy;

  modport master (
    output load, load_data, send_one, send_all, tx_done,
    input  tx_start, tx_data, oldest, count, full, empty, busy
  );

  modport slave (
    input  load, load_data, send_one, send_all, tx_done,
    output tx_start, tx_data, oldest, count, full, empty, busy
  );

endinterface

// File: rtl/uart_tx_sequencer_byte_ring_buffer.sv
// Small byte ring buffer: push at tail, pop at head, head byte decoded from registered state.
// Push visible next cycle; a push while full is dropped, a pop while empty is ignored.
module uart_tx_sequencer_byte_ring_buffer
  import uart_tx_sequencer_pkg::*;
#(
  parameter int DBITS    = DBITS_DEF,
  parameter int FIFO_EXP = FIFO_EXP_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [DBITS-1:0]    push_dat,
  input  logic                pop,
  output logic [DBITS-1:0]    head_dat,
  output logic [FIFO_EXP:0]   count,
  output logic                full,
  output logic                empty
);

  localparam int DEPTH = 2 ** FIFO_EXP;

  logic [DBITS-1:0]    mem_q [DEPTH];
  logic [FIFO_EXP-1:0] head_q, head_d;
  logic [FIFO_EXP-1:0] tail_q, tail_d;
  logic [FIFO_EXP:0]   count_q, count_d;
  logic                push_ok;
  logic                pop_ok;

  // count never exceeds DEPTH, so its MSB alone marks the full condition
  assign full     = count_q[FIFO_EXP];
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_dat = empty ? '0 : mem_q[head_q];

  always_comb begin
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_ok) tail_d = tail_q + 1'b1;
    if (pop_ok)  head_d = head_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[tail_q] <= push_dat;
  end

endmodule

// File: rtl/uart_tx_sequencer.sv
// Buffers switch bytes and feeds them to the UART transmitter one frame or a whole drain at a time.
// send_* to tx_start is 2 cycles; sends while busy or empty are dropped, loads while full are dropped.
module uart_tx_sequencer
  import uart_tx_sequencer_pkg::*;
#(
  parameter int DBITS      = DBITS_DEF,
  parameter int FIFO_EXP   = FIFO_EXP_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  uart_tx_sequencer_if.slave    bus
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [FIFO_EXP:0] ONE = 1;

  tx_seq_state_t      state_q, state_d;
  logic               drain_q, drain_d;
  logic               tx_start_q, tx_start_d;
  logic [DBITS-1:0]   tx_data_q, tx_data_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  logic [DBITS-1:0]   head_dat;
  logic [FIFO_EXP:0]  count;
  logic               full;
  logic               empty;
  logic               pop;
  logic               more_left;

  uart_tx_sequencer_byte_ring_buffer #(
    .DBITS    (DBITS),
    .FIFO_EXP (FIFO_EXP)
  ) u_ring (
    .clk      (clk_100MHz),
    .reset    (reset),
    .push     (bus.load),
    .push_dat (bus.load_data),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // a byte pushed on the same cycle as the pop still belongs to the current drain
  assign more_left = (count > ONE) || (bus.load && !full);

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    gap_d      = gap_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          if (bus.send_all) begin
            drain_d = 1'b1;
            state_d = START;
          end else if (bus.send_one) begin
            drain_d = 1'b0;
            state_d = START;
          end
        end
      end
      START: begin
        tx_data_d  = head_dat;
        tx_start_d = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (bus.tx_done) begin
          pop = 1'b1;
          if (drain_q && more_left) begin
            gap_d   = GAP_W'(GAP_CYCLES - 1);
            state_d = GAP;
          end else begin
            drain_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = START;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q    <= IDLE;
      drain_q    <= 1'b0;
      gap_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      gap_q      <= gap_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.oldest   = head_dat;
  assign bus.count    = count;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: directed scenarios plus random traffic against a queue-based model.
// The model also plays the transmitter, answering each tx_start with tx_done after a chosen delay.
module tb_uart_tx_sequencer;

  localparam int DBITS    = 8;
  localparam int FIFO_EXP = 2;
  localparam int DEPTH    = 4;
  localparam int GAP      = 16;

  logic clk_100MHz = 1'b0;
  logic reset      = 1'b0;

  always #5 clk_100MHz = ~clk_100MHz;

  uart_tx_sequencer_if #(.DBITS(DBITS), .FIFO_EXP(FIFO_EXP)) bus ();

  uart_tx_sequencer #(
    .DBITS      (DBITS),
    .FIFO_EXP   (FIFO_EXP),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .bus        (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: queue of buffered bytes and an abstract view of the send session
  logic [7:0] mq[$];
  bit         sess       = 1'b0;
  bit         drain      = 1'b0;
  bit         frame_out  = 1'b0;
  bit         start_pend = 1'b0;
  int         start_wait = 0;
  int         done_timer = 0;
  int         next_delay = 20;
  logic [7:0] exp_txd    = 8'h00;
  logic [7:0] last_sent  = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick(input bit ld, input logic [7:0] d, input bit s1, input bit sa,
                      input bit stray, input bit rs);
    bit td;
    bit push_ok;
    bit exp_start;
    int sz;
    td = frame_out ? (done_timer == 0) : stray;
    if (frame_out && done_timer > 0) done_timer--;
    reset         = rs;
    bus.load      = ld;
    bus.load_data = d;
    bus.send_one  = s1;
    bus.send_all  = sa;
    bus.tx_done   = td;
    @(posedge clk_100MHz);
    sz = mq.size();
    if (rs) begin
      mq.delete();
      sess       = 1'b0;
      drain      = 1'b0;
      frame_out  = 1'b0;
      start_pend = 1'b0;
      exp_txd    = 8'h00;
    end else begin
      push_ok = ld && (sz < DEPTH);
      if (start_pend) start_wait--;
      if (!sess && sz > 0 && (s1 || sa)) begin
        sess       = 1'b1;
        drain      = sa;
        start_pend = 1'b1;
        start_wait = 1;
      end
      if (push_ok) mq.push_back(d);
      if (frame_out && td) begin
        void'(mq.pop_front());
        frame_out = 1'b0;
        if (drain && mq.size() > 0) begin
          start_pend = 1'b1;
          start_wait = GAP + 1;
        end else begin
          sess  = 1'b0;
          drain = 1'b0;
        end
      end
    end
    #1;
    exp_start = start_pend && (start_wait == 0);
    check_eq("tx_start", 32'(bus.tx_start), 32'(exp_start));
    if (exp_start) begin
      start_pend = 1'b0;
      frame_out  = 1'b1;
      exp_txd    = (mq.size() > 0) ? mq[0] : 8'h00;
      last_sent  = exp_txd;
      done_timer = next_delay;
    end
    check_eq("tx_data", 32'(bus.tx_data), 32'(exp_txd));
    check_eq("busy",    32'(bus.busy),    32'(sess));
    check_eq("count",   32'(bus.count),   32'(mq.size()));
    check_eq("empty",   32'(bus.empty),   32'(mq.size() == 0));
    check_eq("full",    32'(bus.full),    32'(mq.size() == DEPTH));
    check_eq("oldest",  32'(bus.oldest),  32'((mq.size() > 0) ? mq[0] : 8'h00));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_idle(input string tag, input int max_cyc);
    int n;
    n = 0;
    while ((sess || frame_out) && n < max_cyc) begin
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check_eq(tag, 32'(sess || frame_out), 32'd0);
  endtask

  initial begin
    bit pushed77;
    int guard;

    // reset and two loads
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("rst_empty", 32'(bus.empty), 32'd1);
    check_eq("rst_txdata", 32'(bus.tx_data), 32'd0);
    tick(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("t1_count",  32'(bus.count),  32'd2);
    check_eq("t1_oldest", 32'(bus.oldest), 32'hA5);
    check_eq("t1_busy",   32'(bus.busy),   32'd0);

    // single send with a 20-cycle frame
    next_delay = 20;
    tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("t2_latency", 32'(bus.tx_start), 32'd1);
    check_eq("t2_txdata",  32'(bus.tx_data),  32'hA5);
    run_idle("t2_idle_timeout", 100);
    idle(1);
    check_eq("t2_count",  32'(bus.count),  32'd1);
    check_eq("t2_oldest", 32'(bus.oldest), 32'h3C);

    // empty the buffer, fill it, overflow it, drain it
    next_delay = 3;
    tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    run_idle("t3a_idle_timeout", 100);
    for (int i = 1; i <= 4; i++) tick(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("t3_full",   32'(bus.full),   32'd1);
    check_eq("t3_count",  32'(bus.count),  32'd4);
    check_eq("t3_oldest", 32'(bus.oldest), 32'h01);
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    run_idle("t3_idle_timeout", 400);
    check_eq("t3_empty", 32'(bus.empty), 32'd1);
    check_eq("t3_last",  32'(last_sent), 32'h04);

    // push during a drain, including a push on the pop cycle
    next_delay = 5;
    for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    pushed77 = 1'b0;
    guard    = 0;
    while ((sess || frame_out) && guard < 600) begin
      if (!pushed77 && frame_out && done_timer == 0 && mq.size() == 3) begin
        tick(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
        pushed77 = 1'b1;
        check_eq("t4_count_const", 32'(bus.count), 32'd3);
      end else begin
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      guard++;
    end
    check_eq("t4_idle_timeout", 32'(sess || frame_out), 32'd0);
    check_eq("t4_last", 32'(last_sent), 32'h77);
    check_eq("t4_empty", 32'(bus.empty), 32'd1);

    // ignored sends and stray tx_done
    tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    check_eq("t5_empty_busy", 32'(bus.busy), 32'd0);
    tick(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    next_delay = 10;
    tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    run_idle("t5_idle_timeout", 100);
    check_eq("t5_count", 32'(bus.count), 32'd1);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("t5_stray", 32'(bus.count), 32'd1);

    // reset in the middle of a drain
    next_delay = 30;
    for (int i = 0; i < 3; i++) tick(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    guard = 0;
    while (!frame_out && guard < 50) begin
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    idle(2);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("t6_busy",    32'(bus.busy),    32'd0);
    check_eq("t6_count",   32'(bus.count),   32'd0);
    check_eq("t6_txstart", 32'(bus.tx_start), 32'd0);
    check_eq("t6_txdata",  32'(bus.tx_data), 32'd0);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("t6_late_done", 32'(bus.count), 32'd0);

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      next_delay = int'($urandom_range(0, 24));
      tick($urandom_range(0, 9) < 3, 8'($urandom),
           $urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 399) == 0);
    end
    run_idle("rand_idle_timeout", 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
